ysyx_ifq: RTL
=============

# ysyx_ifq

Instruction fetch queue between the IFU and the IDU. It accepts fetched instructions (inst, pc, pnpc) from the IFU through a valid/ready handshake and buffers them in a DEPTH-entry circular FIFO. The IDU drains them in order through a second valid/ready handshake. This decouples I-cache hit/miss timing from decode stalls. A backend redirect `flush` empties the queue in one cycle.

## Interface
Parameters:
- XLEN, `YSYX_XLEN (32): pc/pnpc width.
- DEPTH, 4: number of entries; power of two, ≥2.

Ports (clock/reset first):
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  redirect; discard all entries and any push this cycle.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  pc of the instruction.
- in_pnpc  in  XLEN  predicted next pc.
- out_valid  out  1  head entry available to IDU.
- out_ready  in  1  IDU accepts head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  head pc.
- out_pnpc  out  XLEN  head predicted next pc.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of {inst, pc, pnpc}; no reset on the data array.
- Pointers: head/tail, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty when head==tail. Full when the index bits are equal and the wrap bits differ.
- count = tail − head (modulo 2^(w)); range 0..DEPTH.
- in_ready = !full && !flush && !reset.
- out_valid = !empty && !flush && !reset.
- Push on in_valid && in_ready:
  - write the entry at tail[idx];
  - tail += 1 (wraps naturally).
- Pop on out_valid && out_ready: head += 1.
- Push and pop in the same cycle are both honoured; count is unchanged.
- When full, in_ready is 0 even if a pop occurs that cycle (no full-bypass).
- out_inst/out_pc/out_pnpc always reflect entry head[idx]. Their value is unspecified while out_valid = 0; the bench must not check them then.
- Flush: next cycle head = tail = 0 and count = 0. The flush cycle itself shows in_ready = 0 and out_valid = 0, so no push or pop takes effect.
- Reset: same as flush.
  - During the reset cycle: in_ready = 0, out_valid = 0.
  - After reset: count = 0, in_ready = 1, out_valid = 0.
- Reset or flush asserted mid-stream overrides any simultaneous push or pop.

## Timing
- Latency (bypass disabled): a push in cycle N is visible as out_valid in cycle N+1.
- Throughput: one push and one pop per cycle.
- Handshakes are standard valid/ready:
  - the producer holds valid and data stable until ready;
  - ready may depend combinationally only on the flush and reset inputs and registered state;
  - in_ready does not depend on out_ready, and out_valid does not depend on in_valid, when the bypass is disabled.
- Wrap-around: after DEPTH pushes, tail[idx] returns to 0 and the wrap bit toggles. Full/empty must remain correct across arbitrarily many wraps.

## Configuration
- YSYX_IFQ_BYPASS_EN defined: when the queue is empty and in_valid && !flush && !reset:
  - out_valid = 1 in the same cycle;
  - out_* are driven combinationally from in_*;
  - if out_ready is also 1, the instruction passes through without being written (tail and count unchanged);
  - otherwise it is written normally.
  - Zero-cycle latency when empty.
- YSYX_IFQ_BYPASS_EN undefined: no combinational in→out path; latency is exactly one cycle as above.

## Test plan
- Reset, then 3 pushes (pc 0x8000_0000, 0x8000_0004, 0x8000_0008) with out_ready = 0:
  - count = 3, in_ready = 1;
  - then out_ready = 1 pops in order over 3 cycles;
  - count returns to 0.
- Fill to DEPTH = 4 with out_ready = 0:
  - in_ready = 0 and count = 4;
  - a fifth in_valid is held off;
  - one pop re-raises in_ready next cycle.
- Continuous in_valid = out_ready = 1 for 20 cycles:
  - one instruction per cycle, pc/pnpc/inst in order, count steady;
  - pointers wrap at least 4 times with no loss or duplication.
- Queue holds 2 entries, then flush = 1 with in_valid = 1 (pc 0x8000_0100):
  - flush cycle shows in_ready = 0, out_valid = 0;
  - next cycle count = 0 and pc 0x8000_0100 is not enqueued.
- Reset asserted with count = 3 and simultaneous push/pop:
  - next cycle count = 0, out_valid = 0, in_ready = 1.
- With YSYX_IFQ_BYPASS_EN, empty queue, in_valid = out_ready = 1, pc 0x8000_0200:
  - out_valid = 1 and out_pc = 0x8000_0200 in the same cycle;
  - count stays 0.
- Without YSYX_IFQ_BYPASS_EN, same stimulus: out_valid appears the following cycle.

Source files
------------

// File: rtl/ysyx_ifq.sv
// ysyx_ifq -- instruction fetch queue between the IFU and the IDU.
//
// Buffers fetched instructions {inst, pc, pnpc} in a DEPTH-entry circular
// FIFO so that I-cache hit/miss timing is decoupled from decode stalls.
// A backend redirect (flush) empties the queue in one cycle.
//
// Optional feature macro: YSYX_IFQ_BYPASS_EN
//   defined   -> an instruction arriving at an empty queue is presented on
//                out_* in the same cycle, and skips storage if taken at once.
//   undefined -> no combinational in->out path; latency is one cycle.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               redirect: drop all entries and any push this cycle
//   in_valid/in_ready   IFU handshake; in_inst, in_pc, in_pnpc payload
//   out_valid/out_ready IDU handshake; out_inst, out_pc, out_pnpc = head entry
//   count               current occupancy, 0..DEPTH
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready; the producer holds valid and payload stable until ready.
// ready depends only on flush, reset and registered state.

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_ifq #(
  parameter int XLEN  = `YSYX_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pnpc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pnpc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_pnpc [DEPTH];

  logic empty;
  logic full;
  logic blocked;
  logic push;
  logic pop;

  assign empty   = (head == tail);
  assign full    = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  // Reset and flush both mask the handshakes so nothing moves that cycle.
  assign blocked = flush | reset;

  // Full means not ready even if the head is popped this cycle.
  assign in_ready = !full && !blocked;
  assign count    = tail - head;

`ifdef YSYX_IFQ_BYPASS_EN
  logic bypass;

  assign bypass    = empty && in_valid && !blocked;
  assign out_valid = (!empty && !blocked) || bypass;
  assign out_inst  = bypass ? in_inst : mem_inst[head[AW-1:0]];
  assign out_pc    = bypass ? in_pc   : mem_pc[head[AW-1:0]];
  assign out_pnpc  = bypass ? in_pnpc : mem_pnpc[head[AW-1:0]];
  // A bypassed instruction taken immediately never touches storage.
  assign push      = in_valid && in_ready && !(bypass && out_ready);
  assign pop       = out_valid && out_ready && !bypass;
`else
  assign out_valid = !empty && !blocked;
  assign out_inst  = mem_inst[head[AW-1:0]];
  assign out_pc    = mem_pc[head[AW-1:0]];
  assign out_pnpc  = mem_pnpc[head[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
`endif

  always_ff @(posedge clock) begin
    if (blocked) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + {{AW{1'b0}}, 1'b1};
      if (pop)  head <= head + {{AW{1'b0}}, 1'b1};
    end
  end

  // Data array is not reset; entries are only observed while out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_inst[tail[AW-1:0]] <= in_inst;
      mem_pc[tail[AW-1:0]]   <= in_pc;
      mem_pnpc[tail[AW-1:0]] <= in_pnpc;
    end
  end

endmodule
